// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the 7-segment scan controller
//   SEG_TABLE : BCD -> active-low segment pattern (bit0 = a .. bit6 = g)
//   SEG_OFF   : all segments dark
//   AN_OFF    : all anodes disabled
//   state_t   : scan FSM states
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Codes A-F are not valid BCD and render dark.
    localparam logic [6:0] SEG_TABLE [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, SEG_OFF, SEG_OFF, SEG_OFF, SEG_OFF, SEG_OFF, SEG_OFF
    };

    typedef enum logic {BLANK, ACTIVE} state_t;

endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: combinational BCD to active-low 7-segment decoder
//   bcd_i [3:0] : BCD digit
//   seg_o [6:0] : active-low segments, seg_o[0] = a .. seg_o[6] = g
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[bcd_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 4-digit common-anode 7-segment driver
//   clk, rst_n          : clock, asynchronous active-low reset
//   digits [15:0]       : BCD digits, digit i = digits[4i+3:4i]
//   dp_in/blank_in/blink_in [3:0] : per-digit decimal point, blank, blink
//   an [3:0]            : active-low anode enables
//   seg [6:0], dp       : active-low segments and decimal point
//   digit_idx [1:0]     : digit currently scanned
//   frame_tick          : one-cycle pulse on digit_idx 3->0
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned PRESCALE  = 50000,
    parameter int unsigned DEAD      = 500,
    parameter int unsigned BLINK_DIV = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    input  logic [3:0]  blink_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  digit_idx,
    output logic        frame_tick
);

    localparam int SW = $clog2(PRESCALE);
    localparam int FW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0] PS_LAST   = SW'(PRESCALE - 1);
    localparam logic [SW-1:0] DEAD_LAST = SW'(DEAD - 1);
    localparam logic [FW-1:0] BD_LAST   = FW'(BLINK_DIV - 1);

    state_t        state_q, state_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          phase_q, phase_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          tick_q, tick_d;
    logic [6:0]    pattern;
    logic          visible;

    bcd_to_seg u_dec (
        .bcd_i(digits[{idx_q, 2'b00} +: 4]),
        .seg_o(pattern)
    );

    // The output registers act as the per-slot latch: they are loaded once
    // on entry to ACTIVE and held until the slot ends, so mid-slot input
    // changes are invisible. They go dark before digit_idx advances, so two
    // anodes can never be low at once.
    always_comb begin
        state_d = state_q;
        slot_d  = (slot_q == PS_LAST) ? '0 : slot_q + SW'(1);
        frame_d = frame_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        an_d    = an_q;
        seg_d   = seg_q;
        dp_d    = dp_q;
        tick_d  = 1'b0;
        visible = !blank_in[idx_q] && !(blink_in[idx_q] && phase_q);
        if (state_q == BLANK && slot_q == DEAD_LAST) begin
            state_d = ACTIVE;
            an_d    = visible ? ~(4'b0001 << idx_q) : AN_OFF;
            seg_d   = visible ? pattern : SEG_OFF;
            dp_d    = visible ? ~dp_in[idx_q] : 1'b1;
        end else if (state_q == ACTIVE && slot_q == PS_LAST) begin
            state_d = BLANK;
            an_d    = AN_OFF;
            seg_d   = SEG_OFF;
            dp_d    = 1'b1;
            idx_d   = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                tick_d  = 1'b1;
                frame_d = (frame_q == BD_LAST) ? '0 : frame_q + FW'(1);
                phase_d = phase_q ^ (frame_q == BD_LAST);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BLANK;
            slot_q  <= '0;
            frame_q <= '0;
            phase_q <= 1'b0;
            idx_q   <= 2'd0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            frame_q <= frame_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            tick_q  <= tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign digit_idx  = idx_q;
    assign frame_tick = tick_q;

endmodule
